// File: rtl/cdc_pkg.sv
// Shared constants and helpers for the pulse launch scheduler and its arbiter.
// Holds the default sizing and the requester-index width rule.
package cdc_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int CNT_W_DEF   = 3;
    localparam int GAP_W_DEF   = 8;

    // Index width for a requester population; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC,
        CNT_DROP
    } cnt_op_e;

endpackage

// File: rtl/pulse_launch_sched_rr_arb.sv
// Combinational round-robin picker: scans from last_grant+1 (wrapping) and
// returns the first active request.
module rr_arb
    import cdc_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [id_w(NUM_REQ)-1:0]    last_grant_i,
    output logic                        grant_valid_o,
    output logic [id_w(NUM_REQ)-1:0]    grant_idx_o
);

    localparam int ID_W = id_w(NUM_REQ);

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] sel;
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        idx           = 0;
        sel           = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = int'(last_grant_i) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = ID_W'(idx);
            if (req_i[sel]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = sel;
            end
        end
    end

endmodule

// File: rtl/pulse_launch_sched.sv
// Accumulates per-requester event pulses in saturating counters and launches
// them one at a time, round-robin, with a configurable idle gap between launches.
module pulse_launch_sched
    import cdc_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int GAP_W   = GAP_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [GAP_W-1:0]         cfg_gap,
    input  logic [NUM_REQ-1:0]       req_pulse,
    input  logic [NUM_REQ-1:0]       ovf_clr,
    output logic                     evt_pulse,
    output logic [id_w(NUM_REQ)-1:0] evt_id,
    output logic                     pending_any,
    output logic [NUM_REQ-1:0]       ovf_sticky
);

    localparam int              ID_W      = id_w(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(NUM_REQ - 1);

    logic [CNT_W-1:0]   cnt_q [NUM_REQ];
    logic [CNT_W-1:0]   cnt_d [NUM_REQ];
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               pulse_q, pulse_d;
    logic               pend_q, pend_d;
    logic [NUM_REQ-1:0] ovf_q, ovf_d;

    logic [NUM_REQ-1:0] nz;
    logic [NUM_REQ-1:0] gnt_vec;
    logic [NUM_REQ-1:0] ovf_set;
    logic               grant_valid;
    logic               grant_fire;
    logic [ID_W-1:0]    grant_idx;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            nz[i] = (cnt_q[i] != '0);
        end
    end

    rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arb (
        .req_i         (nz),
        .last_grant_i  (last_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    // A launch is decided only from registered counters, with the gap expired.
    assign grant_fire = en && (gap_q == '0) && grant_valid;

    always_comb begin
        gnt_vec = '0;
        if (grant_fire) begin
            gnt_vec[grant_idx] = 1'b1;
        end
    end

    // Counter update: a grant and a new event in the same cycle cancel out.
    always_comb begin
        cnt_op_e op;
        ovf_set = '0;
        op      = CNT_HOLD;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            case ({req_pulse[i], gnt_vec[i]})
                2'b10:   op = (cnt_q[i] == CNT_MAX) ? CNT_DROP : CNT_INC;
                2'b01:   op = CNT_DEC;
                default: op = CNT_HOLD;
            endcase
            case (op)
                CNT_INC:  cnt_d[i] = cnt_q[i] + CNT_W'(1);
                CNT_DEC:  cnt_d[i] = cnt_q[i] - CNT_W'(1);
                CNT_DROP: ovf_set[i] = 1'b1;
                default:  cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    always_comb begin
        pend_d = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cnt_d[i] != '0) begin
                pend_d = 1'b1;
            end
        end
    end

    // A new drop outranks a clear arriving in the same cycle.
    assign ovf_d = (ovf_q & ~ovf_clr) | ovf_set;

    // The gap countdown runs regardless of en; cfg_gap is only read at a grant.
    always_comb begin
        if (grant_fire) begin
            gap_d = cfg_gap;
        end else if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end else begin
            gap_d = gap_q;
        end
    end

    assign last_d  = grant_fire ? grant_idx : last_q;
    assign pulse_d = grant_fire;
    assign id_d    = grant_fire ? grant_idx : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
            gap_q   <= '0;
            last_q  <= LAST_INIT;
            id_q    <= '0;
            pulse_q <= 1'b0;
            pend_q  <= 1'b0;
            ovf_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            gap_q   <= gap_d;
            last_q  <= last_d;
            id_q    <= id_d;
            pulse_q <= pulse_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign evt_pulse   = pulse_q;
    assign evt_id      = id_q;
    assign pending_any = pend_q;
    assign ovf_sticky  = ovf_q;

endmodule

// File: tb/tb_pulse_launch_sched.sv
// Directed bench for pulse_launch_sched: per-cycle vector tables for the
// timing scenarios plus hand sequences for saturation and mid-burst reset.
module tb_pulse_launch_sched;

    localparam int NR = 4;
    localparam int CW = 3;
    localparam int GW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [GW-1:0] cfg_gap;
    logic [NR-1:0] req_pulse;
    logic [NR-1:0] ovf_clr;
    logic          evt_pulse;
    logic [1:0]    evt_id;
    logic          pending_any;
    logic [NR-1:0] ovf_sticky;

    always #5 clk = ~clk;

    pulse_launch_sched #(
        .NUM_REQ (NR),
        .CNT_W   (CW),
        .GAP_W   (GW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_gap     (cfg_gap),
        .req_pulse   (req_pulse),
        .ovf_clr     (ovf_clr),
        .evt_pulse   (evt_pulse),
        .evt_id      (evt_id),
        .pending_any (pending_any),
        .ovf_sticky  (ovf_sticky)
    );

    // Row r: inputs driven for cycle r, expected outputs observed during cycle r.
    typedef struct {
        logic [NR-1:0] req;
        logic          en;
        logic [NR-1:0] clr;
        logic          pulse;
        logic [1:0]    id;
        logic          pend;
        logic [NR-1:0] ovf;
    } vec_t;

    vec_t vec [32];
    int   n_pass = 0;
    int   n_chk  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic clear_vec();
        for (int i = 0; i < 32; i++) begin
            vec[i] = '{req: '0, en: 1'b1, clr: '0, pulse: 1'b0, id: 2'd0, pend: 1'b0, ovf: '0};
        end
    endtask

    task automatic set_pulse(input int r, input int id);
        vec[r].pulse = 1'b1;
        vec[r].id    = 2'(id);
    endtask

    task automatic set_pend(input int first, input int last);
        for (int r = first; r <= last; r++) vec[r].pend = 1'b1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1; en = 1'b0; req_pulse = '0; ovf_clr = '0;
        repeat (2) @(negedge clk);
        check({tag, " rst evt_pulse"}, int'(evt_pulse), 0);
        check({tag, " rst evt_id"}, int'(evt_id), 0);
        check({tag, " rst pending_any"}, int'(pending_any), 0);
        check({tag, " rst ovf_sticky"}, int'(ovf_sticky), 0);
        rst = 1'b0;
    endtask

    task automatic run_table(input string tag, input int n);
        for (int r = 0; r < n; r++) begin
            @(negedge clk);
            check($sformatf("%s r%0d evt_pulse", tag, r), int'(evt_pulse), int'(vec[r].pulse));
            check($sformatf("%s r%0d evt_id", tag, r), int'(evt_id), int'(vec[r].id));
            check($sformatf("%s r%0d pending_any", tag, r), int'(pending_any), int'(vec[r].pend));
            check($sformatf("%s r%0d ovf_sticky", tag, r), int'(ovf_sticky), int'(vec[r].ovf));
            req_pulse = vec[r].req;
            en        = vec[r].en;
            ovf_clr   = vec[r].clr;
        end
        @(negedge clk);
        req_pulse = '0;
        ovf_clr   = '0;
    endtask

    initial begin
        int launches;
        rst = 1'b1; en = 1'b0; cfg_gap = '0; req_pulse = '0; ovf_clr = '0;

        // Isolated pulse: gap 3, requester 2 at cycle 10 -> launch at cycle 12.
        do_reset("iso");
        cfg_gap = 8'd3;
        clear_vec();
        vec[10].req = 4'b0100;
        set_pend(11, 11);
        set_pulse(12, 2);
        run_table("iso", 16);

        // Round-robin with gap 2: all four at cycle 5 -> ids 0..3 at 7,10,13,16.
        do_reset("rr");
        cfg_gap = 8'd2;
        clear_vec();
        vec[5].req = 4'b1111;
        set_pend(6, 15);
        set_pulse(7, 0);
        set_pulse(10, 1);
        set_pulse(13, 2);
        set_pulse(16, 3);
        run_table("rr", 18);

        // New event on requester 0 in its own grant cycle: count stays 1.
        do_reset("simul");
        cfg_gap = 8'd2;
        clear_vec();
        vec[0].req = 4'b0001;
        vec[1].req = 4'b0001;
        set_pend(1, 4);
        set_pulse(2, 0);
        set_pulse(5, 0);
        run_table("simul", 9);

        // Gap 0, backlog on requesters 0 and 1 -> a launch every cycle, alternating.
        do_reset("gap0");
        cfg_gap = 8'd0;
        clear_vec();
        for (int r = 0; r < 4; r++) vec[r].req = 4'b0011;
        set_pend(1, 8);
        for (int r = 2; r <= 9; r++) set_pulse(r, (r - 2) % 2);
        run_table("gap0", 12);

        // Saturation: 9 events on requester 1 with launches disabled.
        do_reset("sat");
        cfg_gap = 8'd1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            en = 1'b0; req_pulse = 4'b0010;
        end
        @(negedge clk);
        req_pulse = '0;
        @(negedge clk);
        check("sat pending_any", int'(pending_any), 1);
        check("sat ovf_sticky set", int'(ovf_sticky), 2);
        check("sat no launch while disabled", int'(evt_pulse), 0);
        req_pulse = 4'b0010; ovf_clr = 4'b0010;
        @(negedge clk);
        req_pulse = '0; ovf_clr = '0;
        check("sat set beats clear", int'(ovf_sticky), 2);
        en = 1'b1;
        launches = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (evt_pulse) begin
                launches++;
                check("sat launch id", int'(evt_id), 1);
            end
        end
        check("sat launch count", launches, 7);
        check("sat drained pending_any", int'(pending_any), 0);
        check("sat ovf_sticky kept", int'(ovf_sticky), 2);
        ovf_clr = 4'b0010;
        @(negedge clk);
        ovf_clr = '0;
        check("sat ovf_sticky cleared", int'(ovf_sticky), 0);

        // Reset mid-burst with three events pending.
        do_reset("mid");
        cfg_gap = 8'd0;
        @(negedge clk);
        en = 1'b0; req_pulse = 4'b0111;
        @(negedge clk);
        req_pulse = '0;
        @(negedge clk);
        check("mid pending before rst", int'(pending_any), 1);
        rst = 1'b1; en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid evt_pulse after rst", int'(evt_pulse), 0);
        check("mid evt_id after rst", int'(evt_id), 0);
        check("mid pending_any after rst", int'(pending_any), 0);
        check("mid ovf_sticky after rst", int'(ovf_sticky), 0);
        launches = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (evt_pulse) launches++;
        end
        check("mid no launches after rst", launches, 0);
        check("mid pending stays 0", int'(pending_any), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pulse_launch_sched.md
PULSE_LAUNCH_SCHED -- requirements
Module: pulse_launch_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter CNT_W, default 3, meaning width of each requester's pending-event counter.
REQ-003 SHALL have parameter GAP_W, default 8, meaning width of the launch-spacing configuration.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on posedge clk.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port en, input, 1, launch enable; pending events still accumulate when low.
REQ-007 SHALL have port cfg_gap, input, GAP_W, idle cycles enforced between launches.
REQ-008 SHALL have port req_pulse, input, NUM_REQ, one-cycle event pulse per requester.
REQ-009 SHALL have port ovf_clr, input, NUM_REQ, write-1-to-clear for ovf_sticky.
REQ-010 SHALL have port evt_pulse, output, 1, registered one-cycle launch pulse that drives the toggle-synchronizer input.
REQ-011 SHALL have port evt_id, output, clog2(NUM_REQ), requester index of the launch, valid only while evt_pulse is 1 and 0 otherwise.
REQ-012 SHALL have port pending_any, output, 1, registered OR of all nonzero pending counters.
REQ-013 SHALL have port ovf_sticky, output, NUM_REQ, per-requester dropped-event flag.

Function
REQ-014 SHALL keep one saturating counter per requester: +1 on req_pulse, -1 on grant; a simultaneous req_pulse and grant leaves it unchanged.
REQ-015 SHALL, on req_pulse while that counter equals 2^CNT_W-1 and no grant occurs in the same cycle, drop the event, hold the counter, and set that ovf_sticky bit.
REQ-016 SHALL clear an ovf_sticky bit on ovf_clr; a set in the same cycle wins over the clear.
REQ-017 SHALL grant in a cycle only when en=1, gap_cnt=0, and at least one counter is nonzero (counter values registered at the start of the cycle).
REQ-018 SHALL pick the winner round-robin: search starts at last_grant+1 mod NUM_REQ, and last_grant updates only on a grant.
REQ-019 SHALL assert evt_pulse and evt_id in the cycle after the grant decision, for exactly one cycle.
REQ-020 SHALL load gap_cnt with the cfg_gap value sampled at the grant cycle; gap_cnt decrements by 1 per cycle while nonzero, independent of en.
REQ-021 SHALL space consecutive evt_pulse rising edges exactly cfg_gap+1 cycles apart under continuous backlog; cfg_gap=0 gives a pulse every cycle.
REQ-022 SHALL have a latency of 2 cycles from an isolated req_pulse (all idle, gap_cnt=0, en=1) to evt_pulse.
REQ-023 SHALL make en=0 block new grants only; an already-decided pulse still emits, and gap_cnt keeps counting.
REQ-024 SHALL apply a cfg_gap change only to the next grant, never to a running gap_cnt.

Reset
REQ-025 SHALL, while rst=1, clear all counters, gap_cnt, evt_pulse, evt_id, pending_any and ovf_sticky to 0, and set last_grant to NUM_REQ-1 so requester 0 has first priority.
REQ-026 SHALL discard pending events on reset asserted mid-operation, with no evt_pulse in the cycle after rst deasserts.

Structure
REQ-027 SHALL place default parameter constants and the gap/ID widths in the shared package cdc_pkg.
REQ-028 SHALL implement the round-robin search as sub-module rr_arb (inputs: request vector and last_grant; outputs: grant_valid and grant_idx; combinational).

Verification
REQ-029 SHALL test an isolated pulse: cfg_gap=3, req_pulse[2] at cycle 10 -> evt_pulse with evt_id=2 at cycle 12, and nothing else.
REQ-030 SHALL test round-robin with spacing: cfg_gap=2, all four requesters pulse once at cycle 5 -> evt_id 0,1,2,3 at cycles 7,10,13,16.
REQ-031 SHALL test saturation: CNT_W=3, 9 pulses on requester 1 with en=0 -> counter=7 and ovf_sticky[1]=1; set en=1 -> exactly 7 launches; ovf_clr[1] -> bit clears.
REQ-032 SHALL test simultaneous events: requester 0 count=1, req_pulse[0] arrives in its grant cycle -> counter stays 1 and a second launch follows cfg_gap+1 cycles later.
REQ-033 SHALL test reset mid-burst: rst held 1 cycle with 3 pending -> all outputs 0 and no further evt_pulse.
REQ-034 SHALL test cfg_gap=0 with continuous backlog on two requesters -> evt_pulse high every cycle and evt_id alternating 0,1.
